// File: rtl/sim_run_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sim_run_pkg : shared states, config check and slice helper          |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+

// True when a MAX_CYCLES budget is representable in a W-bit counter.
`define SIM_RUN_CNT_FITS(MAXV, W) (((MAXV) >= 1) && (64'(MAXV) <= ((64'd1 << (W)) - 64'd1)))

package sim_run_pkg;

  localparam int unsigned ST_W = 2;

  typedef enum logic [ST_W-1:0] {
    ST_IDLE  = 2'd0,
    ST_RESET = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } run_state_e;

  function automatic int unsigned cc_lsb(input int unsigned core, input int unsigned cnt_w);
    return core * cnt_w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sim_run_ctrl_core_cycle_ctr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | core_cycle_ctr : per-core saturating cycle counter with halt latch  |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+

module core_cycle_ctr
  import sim_run_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             run,
  input  logic             halt,
  output logic [CNT_W-1:0] count,
  output logic             halted
);

  logic [CNT_W-1:0] count_q, count_d;
  logic             halted_q, halted_d;

  always_comb begin
    count_d  = count_q;
    halted_d = halted_q;
    if (clr) begin
      count_d  = '0;
      halted_d = 1'b0;
    end else if (run && !halted_q) begin
      // the halting cycle itself is not charged to the core
      if (halt) begin
        halted_d = 1'b1;
      end else if (count_q != '1) begin
        count_d = count_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q  <= '0;
      halted_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      halted_q <= halted_d;
    end
  end

  assign count  = count_q;
  assign halted = halted_q;

endmodule

`default_nettype wire

// File: rtl/sim_run_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sim_run_ctrl : core reset sequencing, run watchdog, cycle accounting |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+

module sim_run_ctrl
  import sim_run_pkg::*;
#(
  parameter int unsigned     NUM_CORES     = 1,
  parameter int unsigned     CNT_W         = 32,
  parameter int unsigned     RST_CYCLES    = 2,
  parameter longint unsigned MAX_CYCLES    = 100,
  parameter bit              STOP_ON_FIRST = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [NUM_CORES-1:0]       halt,
  output logic                       core_rst,
  output logic                       running,
  output logic [NUM_CORES-1:0]       halted_mask,
  output logic [NUM_CORES*CNT_W-1:0] cycles_consumed,
  output logic [CNT_W-1:0]           total_cycles,
  output logic                       done,
  output logic                       done_pulse,
  output logic                       timeout
);

  localparam int unsigned      RST_W    = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RST_W-1:0] RST_LAST = RST_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(MAX_CYCLES - 1);

  if (!(`SIM_RUN_CNT_FITS(MAX_CYCLES, CNT_W)) || (NUM_CORES < 1) || (RST_CYCLES < 1)) begin : g_bad_cfg
    $error("sim_run_ctrl: illegal parameter set");
  end

  run_state_e           state_q, state_d;
  logic [RST_W-1:0]     rst_cnt_q, rst_cnt_d;
  logic [CNT_W-1:0]     total_q, total_d;
  logic                 timeout_q, timeout_d;
  logic                 done_pulse_q, done_pulse_d;
  logic                 clr;
  logic                 in_run;
  logic                 complete;
  logic                 budget_hit;
  logic [NUM_CORES-1:0] mask;
  logic [NUM_CORES-1:0] mask_nxt;

  assign in_run = (state_q == ST_RUN);

  always_comb begin
    state_d   = state_q;
    rst_cnt_d = rst_cnt_q;
    total_d   = total_q;
    timeout_d = timeout_q;
    clr       = 1'b0;
    // completion looks at the mask as it will be after this edge
    mask_nxt   = mask | halt;
    complete   = STOP_ON_FIRST ? (|mask_nxt) : (&mask_nxt);
    budget_hit = (total_q == RUN_LAST);
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d   = ST_RESET;
          clr       = 1'b1;
          rst_cnt_d = '0;
          total_d   = '0;
          timeout_d = 1'b0;
        end
      end
      ST_RESET: begin
        if (rst_cnt_q == RST_LAST) begin
          state_d = ST_RUN;
        end else begin
          rst_cnt_d = rst_cnt_q + RST_W'(1);
        end
      end
      ST_RUN: begin
        if (total_q != '1) begin
          total_d = total_q + CNT_W'(1);
        end
        if (complete) begin
          state_d   = ST_DONE;
          timeout_d = 1'b0;
        end else if (budget_hit) begin
          state_d   = ST_DONE;
          timeout_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    done_pulse_d = (state_d == ST_DONE) && (state_q != ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      rst_cnt_q    <= '0;
      total_q      <= '0;
      timeout_q    <= 1'b0;
      done_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rst_cnt_q    <= rst_cnt_d;
      total_q      <= total_d;
      timeout_q    <= timeout_d;
      done_pulse_q <= done_pulse_d;
    end
  end

  for (genvar i = 0; i < NUM_CORES; i++) begin : g_core
    core_cycle_ctr #(
      .CNT_W (CNT_W)
    ) u_ctr (
      .clk    (clk),
      .rst    (rst),
      .clr    (clr),
      .run    (in_run),
      .halt   (halt[i]),
      .count  (cycles_consumed[cc_lsb(i, CNT_W) +: CNT_W]),
      .halted (mask[i])
    );
  end

  assign core_rst     = (state_q != ST_RUN);
  assign running      = in_run;
  assign done         = (state_q == ST_DONE);
  assign done_pulse   = done_pulse_q;
  assign timeout      = timeout_q;
  assign halted_mask  = mask;
  assign total_cycles = total_q;

endmodule

`default_nettype wire

// File: tb/tb_sim_run_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_sim_run_ctrl : three configurations, vector table + random runs   |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+

module tb_sim_run_ctrl;

  localparam int CW = 32;
  localparam int NV = 1000;  // "never halts"

  typedef struct {
    logic [31:0] total;
    logic        to;
    logic [3:0]  mask;
    logic [31:0] cnt [4];
  } res_t;

  typedef struct {
    int   d;
    int   h [4];
    res_t e;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] start;
  logic [3:0] hv [3];
  int         n_pass;
  int         n_tot;

  always #5 clk = ~clk;

  // dut 0: 1 core, budget 100; dut 1: 4 cores all-halt; dut 2: 4 cores first-halt, budget 10
  logic          a_crst, a_run, a_mask, a_done, a_dp, a_to;
  logic [CW-1:0] a_cc, a_tot;
  logic          b_crst, b_run, b_done, b_dp, b_to;
  logic [3:0]    b_mask;
  logic [4*CW-1:0] b_cc;
  logic [CW-1:0] b_tot;
  logic          c_crst, c_run, c_done, c_dp, c_to;
  logic [3:0]    c_mask;
  logic [4*CW-1:0] c_cc;
  logic [CW-1:0] c_tot;

  sim_run_ctrl u_a (
    .clk(clk), .rst(rst), .start(start[0]), .halt(hv[0][0]),
    .core_rst(a_crst), .running(a_run), .halted_mask(a_mask), .cycles_consumed(a_cc),
    .total_cycles(a_tot), .done(a_done), .done_pulse(a_dp), .timeout(a_to));

  sim_run_ctrl #(.NUM_CORES(4), .STOP_ON_FIRST(1'b0)) u_b (
    .clk(clk), .rst(rst), .start(start[1]), .halt(hv[1]),
    .core_rst(b_crst), .running(b_run), .halted_mask(b_mask), .cycles_consumed(b_cc),
    .total_cycles(b_tot), .done(b_done), .done_pulse(b_dp), .timeout(b_to));

  sim_run_ctrl #(.NUM_CORES(4), .MAX_CYCLES(10), .STOP_ON_FIRST(1'b1)) u_c (
    .clk(clk), .rst(rst), .start(start[2]), .halt(hv[2]),
    .core_rst(c_crst), .running(c_run), .halted_mask(c_mask), .cycles_consumed(c_cc),
    .total_cycles(c_tot), .done(c_done), .done_pulse(c_dp), .timeout(c_to));

  logic          o_crst [3], o_run [3], o_done [3], o_dp [3], o_to [3];
  logic [3:0]    o_mask [3];
  logic [CW-1:0] o_tot [3];
  logic [4*CW-1:0] o_cc [3];

  always_comb begin
    o_crst[0] = a_crst; o_run[0] = a_run; o_done[0] = a_done; o_dp[0] = a_dp; o_to[0] = a_to;
    o_mask[0] = {3'b000, a_mask}; o_tot[0] = a_tot; o_cc[0] = {96'd0, a_cc};
    o_crst[1] = b_crst; o_run[1] = b_run; o_done[1] = b_done; o_dp[1] = b_dp; o_to[1] = b_to;
    o_mask[1] = b_mask; o_tot[1] = b_tot; o_cc[1] = b_cc;
    o_crst[2] = c_crst; o_run[2] = c_run; o_done[2] = c_done; o_dp[2] = c_dp; o_to[2] = c_to;
    o_mask[2] = c_mask; o_tot[2] = c_tot; o_cc[2] = c_cc;
  end

  task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Run outcome straight from the rules: the run ends at the completing halt
  // cycle or at the budget, whichever is first; each core is charged up to that.
  function automatic res_t model(input int d, input int h [4]);
    res_t r;
    int n, mx, c, tot;
    n  = (d == 0) ? 1 : 4;
    mx = (d == 2) ? 10 : 100;
    c  = h[0];
    for (int i = 1; i < n; i++) begin
      if (d == 2) c = (h[i] < c) ? h[i] : c;
      else        c = (h[i] > c) ? h[i] : c;
    end
    tot     = (c + 1 < mx) ? c + 1 : mx;
    r.total = 32'(tot);
    r.to    = (c + 1 > mx);
    r.mask  = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      r.cnt[i] = 32'd0;
      if (i < n) begin
        r.cnt[i]  = 32'((h[i] < tot) ? h[i] : tot);
        r.mask[i] = (h[i] < tot);
      end
    end
    return r;
  endfunction

  function automatic vec_t mk(input int d, input int h0, input int h1, input int h2, input int h3,
                              input int tot, input bit to, input logic [3:0] m,
                              input int c0, input int c1, input int c2, input int c3);
    vec_t v;
    v.d = d;
    v.h[0] = h0; v.h[1] = h1; v.h[2] = h2; v.h[3] = h3;
    v.e.total = 32'(tot); v.e.to = to; v.e.mask = m;
    v.e.cnt[0] = 32'(c0); v.e.cnt[1] = 32'(c1); v.e.cnt[2] = 32'(c2); v.e.cnt[3] = 32'(c3);
    return v;
  endfunction

  task automatic chk_reset(input string tag, input int d);
    chk({tag, ".reset"},
        {o_crst[d], o_run[d], o_done[d], o_dp[d], o_to[d], o_mask[d], o_tot[d], o_cc[d]},
        {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 32'd0, 128'd0});
  endtask

  task automatic check_run(input string tag, input int d, input int h [4], input res_t e);
    int k, rc, guard, dpc;
    logic [4*CW-1:0] exp_cc;
    k = 0; rc = 0; guard = 0;
    exp_cc = {e.cnt[3], e.cnt[2], e.cnt[1], e.cnt[0]};
    for (int i = 0; i < 4; i++) hv[d][i] = (h[i] == 0);
    start[d] = 1'b1;
    @(negedge clk);
    start[d] = 1'b0;
    while (!o_done[d] && guard < 400) begin
      if (o_run[d]) begin
        for (int i = 0; i < 4; i++) hv[d][i] = (k >= h[i]);
        start[d] = (k == 3);
        k++;
      end else begin
        if (o_crst[d]) rc++;
        start[d] = (rc == 1);
      end
      @(negedge clk);
      guard++;
    end
    start[d] = 1'b0;
    chk({tag, ".done_seen"}, 192'(guard < 400), 192'(1));
    chk({tag, ".rst_cycles"}, 192'(rc), 192'(2));
    chk({tag, ".run_cycles"}, 192'(k), 192'(e.total));
    chk({tag, ".total"}, 192'(o_tot[d]), 192'(e.total));
    chk({tag, ".timeout"}, 192'(o_to[d]), 192'(e.to));
    chk({tag, ".mask"}, 192'(o_mask[d]), 192'(e.mask));
    chk({tag, ".counts"}, 192'(o_cc[d]), 192'(exp_cc));
    dpc = int'(o_dp[d]);
    hv[d] = 4'hF;
    repeat (3) begin
      @(negedge clk);
      dpc += int'(o_dp[d]);
    end
    chk({tag, ".done_pulse_cnt"}, 192'(dpc), 192'(1));
    chk({tag, ".frozen"}, {o_done[d], o_crst[d], o_run[d], o_to[d], o_mask[d], o_tot[d], o_cc[d]},
        {1'b1, 1'b1, 1'b0, e.to, e.mask, e.total, exp_cc});
    hv[d] = 4'h0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  vec_t tbl [7];

  initial begin
    int h [4];
    int guard;
    n_pass = 0;
    n_tot  = 0;
    rst    = 1'b1;
    start  = 3'b000;
    for (int d = 0; d < 3; d++) hv[d] = 4'h0;

    tbl[0] = mk(0, 37, NV, NV, NV, 38, 1'b0, 4'b0001, 37, 0, 0, 0);
    tbl[1] = mk(0, NV, NV, NV, NV, 100, 1'b1, 4'b0000, 100, 0, 0, 0);
    tbl[2] = mk(1, 5, 20, 12, 50, 51, 1'b0, 4'b1111, 5, 20, 12, 50);
    tbl[3] = mk(2, 5, 20, 12, 50, 6, 1'b0, 4'b0001, 5, 6, 6, 6);
    tbl[4] = mk(2, 9, NV, NV, NV, 10, 1'b0, 4'b0001, 9, 10, 10, 10);
    tbl[5] = mk(0, 0, NV, NV, NV, 1, 1'b0, 4'b0001, 0, 0, 0, 0);
    tbl[6] = mk(2, NV, NV, NV, NV, 10, 1'b1, 4'b0000, 10, 10, 10, 10);

    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) chk_reset($sformatf("por%0d", d), d);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) check_run($sformatf("vec%0d", i), tbl[i].d, tbl[i].h, tbl[i].e);

    // reset in the middle of a run, with ignored start pulses inside RUN
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    guard = 0;
    while (o_tot[0] != 32'd30 && guard < 200) begin
      start[0] = o_run[0] && (o_tot[0][2:0] == 3'd5);
      @(negedge clk);
      guard++;
    end
    start[0] = 1'b0;
    chk("midrun.reach30", 192'(o_tot[0]), 192'(30));
    rst = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 3; d++) chk_reset($sformatf("midrun%0d", d), d);
    rst = 1'b0;
    h = '{7, NV, NV, NV};
    check_run("rerun", 0, h, model(0, h));

    for (int r = 0; r < 24; r++) begin
      int d;
      d = int'($urandom_range(0, 2));
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 4) == 0) h[i] = NV;
        else h[i] = int'((d == 2) ? $urandom_range(0, 14) : $urandom_range(0, 110));
      end
      check_run($sformatf("rnd%0d_d%0d", r, d), d, h, model(d, h));
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

`default_nettype wire
